disp_write_arbiter: RTL and testbench
=====================================

Name: disp_write_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 8-digit display memory's single write port (write/sel/num) among NUM_REQ requesters, e.g. switch entry, counter, UART.
- Sits between the requesters and the display-memory block.
- Drives one registered write per grant.
- A requester can lock ownership for a burst of up to DIGITS writes, for an atomic full-frame update.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIGITS, 8, display digits; also the burst cap per lock.
- SEL_W, 3, digit-select width, clog2(DIGITS).
- VAL_W, 4, digit value width.
- LOCK_TIMEOUT, 16, idle cycles before a forced lock release (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-requester write request; held high with data stable until ack
- lock  in  NUM_REQ  per-requester burst-lock request; sampled at grant and during ownership
- req_sel  in  NUM_REQ*SEL_W  flat packed digit index; requester i uses bits [i*SEL_W +: SEL_W]
- req_num  in  NUM_REQ*VAL_W  flat packed digit value; same packing as req_sel
- ack  out  NUM_REQ  one-cycle pulse to the served requester, coincident with write_o
- write_o  out  1  write strobe to the display memory
- sel_o  out  SEL_W  digit index to the display memory
- num_o  out  VAL_W  digit value to the display memory
- owner  out  clog2(NUM_REQ)  index of the current or last winner
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer ptr=0, burst_cnt=0.
  - Reset asserted mid-write or mid-burst aborts immediately.
  - No write_o is issued after reset asserts.
- States: IDLE, WRITE, LOCK_IDLE.
- All outputs are registered. write_o, ack[owner], sel_o and num_o are valid only while in WRITE.
  - sel_o and num_o hold their last value otherwise.
- IDLE:
  - If any req is high, pick the winner: first set bit searching ptr, ptr+1, … mod NUM_REQ.
  - Latch owner, the winner's sel/num and locked=lock[winner]; go to WRITE.
  - Latency: req seen in cycle N gives write_o/ack in cycle N+1.
- WRITE (exactly 1 cycle): write_o=1, ack[owner]=1. Then:
  - If locked, lock[owner] is high and burst_cnt < DIGITS-1: burst_cnt++, go to LOCK_IDLE.
  - Otherwise: ptr = (owner+1) mod NUM_REQ, burst_cnt=0, go to IDLE.
- LOCK_IDLE:
  - Other requesters are ignored.
  - If lock[owner] is low, release: ptr = owner+1, go to IDLE. Release wins over a simultaneous req[owner].
  - Else if req[owner] is high, latch data and go to WRITE.
- Throughput: at most one write per 2 cycles.
  - The served requester's req in the WRITE cycle is never re-granted, because the FSM is not in IDLE or LOCK_IDLE.
  - A requester must drop or refresh req the cycle after ack.
- Burst cap: the DIGITS-th write in a lock releases ownership even if lock stays high. Lock must deassert then reassert to start a new burst.
- Wrap-around: ptr = NUM_REQ-1 advances to 0. burst_cnt is SEL_W+1 bits wide and never overflows.
- Fairness: with all req held high and no locks, grant order is 0,1,2,3,0,…
- Out-of-range data: sel/num pass through unmodified. No range checking; SEL_W fixes the range.

Optional Feature:
- Macro DISP_ARB_LOCK_TIMEOUT_EN.
- With the macro:
  - Adds output port timeout_o (1 bit) and an idle counter in LOCK_IDLE.
  - The counter resets on each entry to LOCK_IDLE.
  - After LOCK_TIMEOUT consecutive LOCK_IDLE cycles without req[owner], force release (ptr = owner+1, go to IDLE) and pulse timeout_o for 1 cycle.
- Without the macro: no port, no counter; a lock holds indefinitely until lock drops or the burst cap is reached.

Decomposition:
- Package disp_arb_pkg holds:
  - state enum type arb_state_t {IDLE, WRITE, LOCK_IDLE};
  - localparams DIGITS=8, SEL_W=3, VAL_W=4;
  - type digit_t (logic [VAL_W-1:0]).
- Sub-module rr_picker: combinational.
  - Inputs: req vector and ptr.
  - Outputs: grant_valid and grant_idx, via a double-width masked priority search.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single request: req=0001, sel=5, num=A → write_o, ack[0], sel_o=5 and num_o=A all in the cycle after req; busy high for 1 cycle.
- Fairness: req=1111 held, no locks, per-requester distinct data → acks in order 0,1,2,3,0, one every 2 cycles; each sel_o/num_o matches the owner's data.
- Burst: requester 2 holds lock and writes digits 0..7 while req=1111 → 8 consecutive writes all to owner 2; forced release after the 8th; next grant goes to requester 3.
- Early release: requester 1 locks, makes 3 writes, then drops lock while req[1] stays high → 4th write not issued; next grant goes to requester 2; burst_cnt back to 0.
- Async reset: assert reset during WRITE of a burst → write_o, ack and busy drop immediately; after release, req=1000 is granted by search from ptr=0, and requester 3 is served.
- With DISP_ARB_LOCK_TIMEOUT_EN: requester 0 locks, writes once, then idles with lock high → timeout_o pulses after 16 LOCK_IDLE cycles; requester 1's pending req is granted the following cycle.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// rtl/disp_arb_pkg.sv - shared types and constants for the display write arbiter
package disp_arb_pkg;

   localparam int DIGITS = 8;
   localparam int SEL_W  = 3;
   localparam int VAL_W  = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      LOCK_IDLE = 2'd2
   } arb_state_t;

   typedef logic [VAL_W-1:0] digit_t;

endpackage

// File: rtl/disp_write_arbiter_rr_picker.sv
// rtl/disp_write_arbiter_rr_picker.sv - combinational round-robin picker
// Finds the first set req bit at or after ptr (wrapping) via a doubled, masked priority search.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [2*NUM_REQ-1:0] mask;
   logic [2*NUM_REQ-1:0] masked;

   always_comb begin
      dbl         = {req, req};
      mask        = '1 << ptr;
      masked      = dbl & mask;
      grant_valid = |req;
      grant_idx   = '0;
      // Descending scan so the lowest set position wins; the upper copy covers the wrap.
      for (int k = 2*NUM_REQ-1; k >= 0; k--) begin
         if (masked[k]) begin
            grant_idx = (k >= NUM_REQ) ? IDX_W'(k - NUM_REQ) : IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/disp_write_arbiter.sv
// rtl/disp_write_arbiter.sv - round-robin owner of the display memory write port with burst locks
// Optional lock-idle timeout and timeout_o port under DISP_ARB_LOCK_TIMEOUT_EN.
module disp_write_arbiter
   import disp_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DIGITS       = disp_arb_pkg::DIGITS,
   parameter int SEL_W        = disp_arb_pkg::SEL_W,
   parameter int VAL_W        = disp_arb_pkg::VAL_W,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         lock,
   input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
   input  logic [NUM_REQ*VAL_W-1:0]   req_num,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       write_o,
   output logic [SEL_W-1:0]           sel_o,
   output logic [VAL_W-1:0]           num_o,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy
`ifdef DISP_ARB_LOCK_TIMEOUT_EN
   ,
   output logic                       timeout_o
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [SEL_W:0] BURST_LAST = (SEL_W+1)'(DIGITS-1);

   arb_state_t           state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [VAL_W-1:0]     num_q, num_d;
   logic                 locked_q, locked_d;
   logic [SEL_W:0]       burst_q, burst_d;
   logic                 write_q, write_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 busy_q, busy_d;

   logic                 grant_valid;
   logic [IDX_W-1:0]     grant_idx;
   logic [IDX_W-1:0]     src_idx;
   logic [IDX_W-1:0]     owner_next;

`ifdef DISP_ARB_LOCK_TIMEOUT_EN
   localparam int TO_W = $clog2(LOCK_TIMEOUT+1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT-1);
   logic [TO_W-1:0] idle_q, idle_d;
   logic            timeout_q, timeout_d;
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req         (req),
      .ptr         (ptr_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign owner_next = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
   assign src_idx    = (state_q == IDLE) ? grant_idx : owner_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         sel_q    <= '0;
         num_q    <= '0;
         locked_q <= 1'b0;
         burst_q  <= '0;
         write_q  <= 1'b0;
         ack_q    <= '0;
         busy_q   <= 1'b0;
`ifdef DISP_ARB_LOCK_TIMEOUT_EN
         idle_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         sel_q    <= sel_d;
         num_q    <= num_d;
         locked_q <= locked_d;
         burst_q  <= burst_d;
         write_q  <= write_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
`ifdef DISP_ARB_LOCK_TIMEOUT_EN
         idle_q    <= idle_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) state_d = WRITE;
         end
         WRITE: begin
            if (locked_q && lock[owner_q] && (burst_q < BURST_LAST)) state_d = LOCK_IDLE;
            else                                                     state_d = IDLE;
         end
         LOCK_IDLE: begin
            // Release beats a simultaneous req from the owner.
            if (!lock[owner_q])    state_d = IDLE;
            else if (req[owner_q]) state_d = WRITE;
`ifdef DISP_ARB_LOCK_TIMEOUT_EN
            else if (idle_q == TO_LAST) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      sel_d    = sel_q;
      num_d    = num_q;
      locked_d = locked_q;
      burst_d  = burst_q;
      write_d  = 1'b0;
      ack_d    = '0;
      busy_d   = (state_d != IDLE);
`ifdef DISP_ARB_LOCK_TIMEOUT_EN
      idle_d    = '0;
      timeout_d = 1'b0;
`endif

      if (state_d == WRITE) begin
         sel_d   = req_sel[src_idx*SEL_W +: SEL_W];
         num_d   = req_num[src_idx*VAL_W +: VAL_W];
         write_d = 1'b1;
         ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << src_idx;
         if (state_q == IDLE) begin
            owner_d  = grant_idx;
            locked_d = lock[grant_idx];
         end
      end

      if (state_q == WRITE && state_d == LOCK_IDLE) burst_d = burst_q + 1'b1;

      if (state_q != IDLE && state_d == IDLE) begin
         ptr_d   = owner_next;
         burst_d = '0;
      end

`ifdef DISP_ARB_LOCK_TIMEOUT_EN
      if (state_q == LOCK_IDLE && state_d == LOCK_IDLE) idle_d = idle_q + 1'b1;
      timeout_d = (state_q == LOCK_IDLE) && (state_d == IDLE) && lock[owner_q];
`endif
   end

   assign ack     = ack_q;
   assign write_o = write_q;
   assign sel_o   = sel_q;
   assign num_o   = num_q;
   assign owner   = owner_q;
   assign busy    = busy_q;
`ifdef DISP_ARB_LOCK_TIMEOUT_EN
   assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_disp_write_arbiter.sv
// tb/tb_disp_write_arbiter.sv - directed self-checking bench for disp_write_arbiter
module tb_disp_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [11:0] req_sel;
   logic [15:0] req_num;
   logic [3:0]  ack;
   logic        write_o;
   logic [2:0]  sel_o;
   logic [3:0]  num_o;
   logic [1:0]  owner;
   logic        busy;
`ifdef DISP_ARB_LOCK_TIMEOUT_EN
   logic        timeout_o;
`endif

   int n_run  = 0;
   int n_fail = 0;

   logic [2:0] f_sel [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
   logic [3:0] f_num [4] = '{4'h9, 4'hA, 4'hB, 4'hF};

   disp_write_arbiter dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .lock    (lock),
      .req_sel (req_sel),
      .req_num (req_num),
      .ack     (ack),
      .write_o (write_o),
      .sel_o   (sel_o),
      .num_o   (num_o),
      .owner   (owner),
      .busy    (busy)
`ifdef DISP_ARB_LOCK_TIMEOUT_EN
      ,
      .timeout_o (timeout_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [2:0] s, input logic [3:0] n);
      req_sel[i*3 +: 3] = s;
      req_num[i*4 +: 4] = n;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      lock  = '0;
      repeat (2) step();
      reset = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic [1:0] o,
                              input logic [2:0] s, input logic [3:0] n);
      check({tag, " write"}, 32'(write_o), 32'd1);
      check({tag, " ack"},   32'(ack),     32'(4'b0001 << o));
      check({tag, " owner"}, 32'(owner),   32'(o));
      check({tag, " sel"},   32'(sel_o),   32'(s));
      check({tag, " num"},   32'(num_o),   32'(n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      req     = '0;
      lock    = '0;
      req_sel = '0;
      req_num = '0;
      repeat (2) step();
      check("rst write", 32'(write_o), 32'd0);
      check("rst ack",   32'(ack),     32'd0);
      check("rst busy",  32'(busy),    32'd0);
      check("rst owner", 32'(owner),   32'd0);
      check("rst sel",   32'(sel_o),   32'd0);
      check("rst num",   32'(num_o),   32'd0);
      reset = 1'b0;
      step();

      // Single request
      set_data(0, 3'd5, 4'hA);
      req = 4'b0001;
      step();
      check_write("single", 2'd0, 3'd5, 4'hA);
      check("single busy", 32'(busy), 32'd1);
      req = '0;
      step();
      check("single busy after", 32'(busy),    32'd0);
      check("single write after", 32'(write_o), 32'd0);
      check("single sel hold",   32'(sel_o),   32'd5);
      check("single num hold",   32'(num_o),   32'hA);

      // Fairness with wrap 3 -> 0
      do_reset();
      for (int i = 0; i < 4; i++) set_data(i, f_sel[i], f_num[i]);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         check_write("fair", 2'(k % 4), f_sel[k % 4], f_num[k % 4]);
         step();
         check("fair gap", 32'(write_o), 32'd0);
      end
      req = '0;
      step();

      // Locked burst by requester 2, capped at 8 writes
      req  = 4'b0100;
      lock = 4'b0100;
      set_data(2, 3'd0, 4'hF);
      for (int k = 0; k < 8; k++) begin
         step();
         check_write("burst", 2'd2, 3'(k), 4'(15 - k));
         req = 4'b1111;
         set_data(2, 3'(k + 1), 4'(14 - k));
         step();
         check("burst gap write", 32'(write_o), 32'd0);
         check("burst gap busy",  32'(busy),    (k < 7) ? 32'd1 : 32'd0);
      end
      step();
      check_write("burst next", 2'd3, 3'd7, 4'hF);
      req  = '0;
      lock = '0;
      step();

      // Early release by requester 1 after 3 writes
      set_data(1, 3'd2, 4'h3);
      set_data(2, 3'd6, 4'hB);
      req  = 4'b0110;
      lock = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         step();
         check_write("early", 2'd1, 3'd2, 4'h3);
         step();
         check("early lockidle busy",  32'(busy),    32'd1);
         check("early lockidle write", 32'(write_o), 32'd0);
      end
      lock = '0;
      step();
      check("early release write", 32'(write_o), 32'd0);
      check("early release busy",  32'(busy),    32'd0);
      step();
      check_write("early next", 2'd2, 3'd6, 4'hB);
      req = '0;
      step();

      // Async reset during a burst write
      req  = 4'b0010;
      lock = 4'b0010;
      step();
      check("areset pre ack", 32'(ack), 32'b0010);
      reset = 1'b1;
      #1;
      check("areset write", 32'(write_o), 32'd0);
      check("areset ack",   32'(ack),     32'd0);
      check("areset busy",  32'(busy),    32'd0);
      check("areset owner", 32'(owner),   32'd0);
      step();
      reset = 1'b0;
      req   = 4'b1000;
      lock  = '0;
      step();
      check_write("areset next", 2'd3, 3'd7, 4'hF);
      req = '0;
      step();

`ifdef DISP_ARB_LOCK_TIMEOUT_EN
      do_reset();
      req  = 4'b0011;
      lock = 4'b0001;
      step();
      check("to first ack", 32'(ack), 32'b0001);
      req = 4'b0010;
      for (int j = 0; j < 16; j++) begin
         step();
         check("to idle timeout", 32'(timeout_o), 32'd0);
         check("to idle write",   32'(write_o),   32'd0);
      end
      step();
      check("to pulse", 32'(timeout_o), 32'd1);
      check("to busy",  32'(busy),      32'd0);
      step();
      check("to pulse end", 32'(timeout_o), 32'd0);
      check("to next ack",  32'(ack),       32'b0010);
`else
      do_reset();
      req  = 4'b0001;
      lock = 4'b0001;
      step();
      check("hold first ack", 32'(ack), 32'b0001);
      req = 4'b0010;
      repeat (20) step();
      check("hold busy",  32'(busy),    32'd1);
      check("hold owner", 32'(owner),   32'd0);
      check("hold write", 32'(write_o), 32'd0);
      lock = '0;
      step();
      check("hold release busy", 32'(busy), 32'd0);
      step();
      check("hold next ack", 32'(ack), 32'b0010);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
